// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage pipeline: merges stalls, redirects, traps and
// fence.i into per-stage enables/flushes, PC redirect select and stall/flush counters.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_valid,
   input  logic             ifu_busy,
   input  logic             if_id_stall,
   input  logic             ex_mdu_busy,
   input  logic             mem_lsu_busy,
   input  logic             ex_redirect,
   input  logic             mem_trap,
   input  logic             mem_fencei,
   input  logic             icache_flush_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             redirect_valid,
   output logic [1:0]       redirect_src,
   output logic             icache_flush_req,
   output logic             ifu_discard,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, SQUASH, FENCE_WAIT} state_t;

   localparam logic [1:0] SRC_NONE   = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_TRAP   = 2'b10;
   localparam logic [1:0] SRC_FENCE  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_p0, state_nxt;
   logic [CNT_W-1:0] stall_cnt_p0, flush_cnt_p0;
   logic             trap_acc, fence_acc, br_acc;
   logic             fetch_pending;

   assign trap_acc      = mem_trap & ~mem_lsu_busy;
   assign fence_acc     = mem_fencei & ~mem_lsu_busy & ~mem_trap;
   assign br_acc        = ex_redirect & ~ex_mdu_busy & ~mem_lsu_busy & ~mem_trap & ~mem_fencei;
   assign fetch_pending = ifu_busy & ~ifu_valid;

   always_comb begin
      pc_en            = 1'b1;
      if_id_en         = 1'b1;
      id_ex_en         = 1'b1;
      ex_mem_en        = 1'b1;
      mem_wb_en        = 1'b1;
      if_id_flush      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_flush     = 1'b0;
      mem_wb_flush     = 1'b0;
      redirect_valid   = 1'b0;
      redirect_src     = SRC_NONE;
      icache_flush_req = 1'b0;
      ifu_discard      = 1'b0;
      state_nxt        = state_p0;

      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         state_nxt    = RUN;
      end else if (state_p0 == FENCE_WAIT) begin
         // Pipeline drains to bubbles; branch/trap inputs are ignored here.
         pc_en            = 1'b0;
         if_id_flush      = 1'b1;
         id_ex_flush      = 1'b1;
         ex_mem_flush     = 1'b1;
         mem_wb_flush     = 1'b1;
         icache_flush_req = ~ifu_busy;
         ifu_discard      = ifu_valid;
         if (icache_flush_done) begin
            redirect_valid = 1'b1;
            redirect_src   = SRC_FENCE;
            pc_en          = 1'b1;
            state_nxt      = fetch_pending ? SQUASH : RUN;
         end
      end else if (trap_acc) begin
         redirect_valid = 1'b1;
         redirect_src   = SRC_TRAP;
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         ex_mem_flush   = 1'b1;
         mem_wb_flush   = 1'b1;
         ifu_discard    = ifu_valid;
         state_nxt      = (state_p0 == SQUASH || fetch_pending) ? SQUASH : RUN;
      end else if (fence_acc) begin
         pc_en        = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         ifu_discard  = (state_p0 == SQUASH) & ifu_valid;
         state_nxt    = FENCE_WAIT;
      end else if (br_acc) begin
         redirect_valid = 1'b1;
         redirect_src   = SRC_BRANCH;
         if_id_flush    = 1'b1;
         id_ex_flush    = 1'b1;
         ifu_discard    = ifu_valid;
         state_nxt      = (state_p0 == SQUASH || fetch_pending) ? SQUASH : RUN;
      end else begin
         if (mem_lsu_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
         end else if (ex_mdu_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
         end else if (if_id_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end else if (!ifu_valid) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
         end
         // Squash bubbles IF/ID only when it advances; a frozen IF/ID holds a live instruction.
         if (state_p0 == SQUASH) begin
            pc_en       = 1'b0;
            if_id_flush = if_id_en;
            ifu_discard = ifu_valid;
            if (ifu_valid)
               state_nxt = RUN;
         end
      end
   end

   // Stage p0: controller state and performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0     <= RUN;
         stall_cnt_p0 <= '0;
         flush_cnt_p0 <= '0;
      end else begin
         state_p0 <= state_nxt;
         if (!pc_en)
            stall_cnt_p0 <= stall_cnt_p0 + CNT_ONE;
         if (redirect_valid)
            flush_cnt_p0 <= flush_cnt_p0 + CNT_ONE;
      end
   end

   assign stall_cnt = stall_cnt_p0;
   assign flush_cnt = flush_cnt_p0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed input vectors push expected outputs,
// a negedge monitor pops and compares. Narrow counters make the wrap reachable.
module tb_pipeline_ctrl;

   localparam int CNT_W = 4;

   localparam logic [9:0] NONE = 10'd0;
   localparam logic [9:0] RST  = 10'd512;
   localparam logic [9:0] VLD  = 10'd256;
   localparam logic [9:0] BSY  = 10'd128;
   localparam logic [9:0] STL  = 10'd64;
   localparam logic [9:0] MDU  = 10'd32;
   localparam logic [9:0] LSU  = 10'd16;
   localparam logic [9:0] BR   = 10'd8;
   localparam logic [9:0] TRP  = 10'd4;
   localparam logic [9:0] FNC  = 10'd2;
   localparam logic [9:0] DONE = 10'd1;

   logic clk = 1'b0;
   logic rst, ifu_valid, ifu_busy, if_id_stall, ex_mdu_busy, mem_lsu_busy;
   logic ex_redirect, mem_trap, mem_fencei, icache_flush_done;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic redirect_valid, icache_flush_req, ifu_discard;
   logic [1:0] redirect_src;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   typedef struct packed {
      logic [4:0] en;
      logic [3:0] fl;
      logic       rv;
      logic [1:0] src;
      logic       req;
      logic       disc;
   } outs_t;

   typedef struct {
      outs_t o;
      int    s;
      int    f;
      int    id;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   outs_t act;
   int total = 0;
   int bad = 0;
   int vec_id = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_busy(ifu_busy),
      .if_id_stall(if_id_stall), .ex_mdu_busy(ex_mdu_busy), .mem_lsu_busy(mem_lsu_busy),
      .ex_redirect(ex_redirect), .mem_trap(mem_trap), .mem_fencei(mem_fencei),
      .icache_flush_done(icache_flush_done),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .redirect_valid(redirect_valid), .redirect_src(redirect_src),
      .icache_flush_req(icache_flush_req), .ifu_discard(ifu_discard),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic apply(input logic [9:0] in);
      {rst, ifu_valid, ifu_busy, if_id_stall, ex_mdu_busy, mem_lsu_busy,
       ex_redirect, mem_trap, mem_fencei, icache_flush_done} = in;
   endtask

   // s/f < 0 means the counter is not checked on that vector
   task automatic step(input logic [9:0] in, input logic [4:0] en, input logic [3:0] fl,
                       input logic rv, input logic [1:0] src, input logic req,
                       input logic disc, input int s, input int f);
      exp_t e;
      @(posedge clk);
      #1;
      apply(in);
      vec_id++;
      e.o  = '{en: en, fl: fl, rv: rv, src: src, req: req, disc: disc};
      e.s  = s;
      e.f  = f;
      e.id = vec_id;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         act = '{en: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                 fl: {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
                 rv: redirect_valid, src: redirect_src, req: icache_flush_req,
                 disc: ifu_discard};
         total++;
         if (act !== cur.o) begin
            bad++;
            $display("FAIL vec%0d outs: got en=%b fl=%b rv=%b src=%b req=%b disc=%b, want en=%b fl=%b rv=%b src=%b req=%b disc=%b",
                     cur.id, act.en, act.fl, act.rv, act.src, act.req, act.disc,
                     cur.o.en, cur.o.fl, cur.o.rv, cur.o.src, cur.o.req, cur.o.disc);
         end
         if (cur.s >= 0) begin
            total++;
            if (stall_cnt !== CNT_W'(cur.s)) begin
               bad++;
               $display("FAIL vec%0d stall_cnt: got %0d want %0d", cur.id, stall_cnt, cur.s);
            end
         end
         if (cur.f >= 0) begin
            total++;
            if (flush_cnt !== CNT_W'(cur.f)) begin
               bad++;
               $display("FAIL vec%0d flush_cnt: got %0d want %0d", cur.id, flush_cnt, cur.f);
            end
         end
      end
   end

   initial begin
      apply(RST);
      // reset
      step(RST | VLD,        5'b00000, 4'b1111, 0, 2'b00, 0, 0, -1, -1);
      step(RST,              5'b00000, 4'b1111, 0, 2'b00, 0, 0,  0,  0);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  0,  0);
      // load-use, fetch bubble, mdu stall
      step(VLD | STL,        5'b00111, 4'b0100, 0, 2'b00, 0, 0,  0,  0);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  1,  0);
      step(NONE,             5'b01111, 4'b1000, 0, 2'b00, 0, 0,  1,  0);
      step(VLD | MDU | BR,   5'b00011, 4'b0010, 0, 2'b00, 0, 0,  2,  0);
      // lsu busy holds the branch for 3 cycles
      step(VLD | LSU | BR,   5'b00001, 4'b0001, 0, 2'b00, 0, 0,  3,  0);
      step(VLD | LSU | BR,   5'b00001, 4'b0001, 0, 2'b00, 0, 0,  4,  0);
      step(VLD | LSU | BR,   5'b00001, 4'b0001, 0, 2'b00, 0, 0,  5,  0);
      step(VLD | BR,         5'b11111, 4'b1100, 1, 2'b01, 0, 1,  6,  0);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  6,  1);
      // branch with outstanding fetch -> squash
      step(BR | BSY,         5'b11111, 4'b1100, 1, 2'b01, 0, 0,  6,  1);
      step(BSY,              5'b01111, 4'b1000, 0, 2'b00, 0, 0,  6,  2);
      step(VLD,              5'b01111, 4'b1000, 0, 2'b00, 0, 1,  7,  2);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  8,  2);
      // trap beats branch, counted once
      step(VLD | TRP | BR,   5'b11111, 4'b1111, 1, 2'b10, 0, 1,  8,  2);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  8,  3);
      // fence.i with fetch outstanding
      step(FNC | BSY,        5'b01111, 4'b1110, 0, 2'b00, 0, 0,  8,  3);
      step(BSY,              5'b01111, 4'b1111, 0, 2'b00, 0, 0,  9,  3);
      step(BSY | TRP | BR,   5'b01111, 4'b1111, 0, 2'b00, 0, 0, 10,  3);
      step(VLD,              5'b01111, 4'b1111, 0, 2'b00, 1, 1, 11,  3);
      step(DONE,             5'b11111, 4'b1111, 1, 2'b11, 1, 0, 12,  3);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0, 12,  4);
      // stall counter wrap
      step(NONE,             5'b01111, 4'b1000, 0, 2'b00, 0, 0, 12,  4);
      step(NONE,             5'b01111, 4'b1000, 0, 2'b00, 0, 0, 13,  4);
      step(NONE,             5'b01111, 4'b1000, 0, 2'b00, 0, 0, 14,  4);
      step(NONE,             5'b01111, 4'b1000, 0, 2'b00, 0, 0, 15,  4);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  0,  4);
      // reset while in FENCE_WAIT
      step(FNC,              5'b01111, 4'b1110, 0, 2'b00, 0, 0,  0,  4);
      step(NONE,             5'b01111, 4'b1111, 0, 2'b00, 1, 0,  1,  4);
      step(RST,              5'b00000, 4'b1111, 0, 2'b00, 0, 0,  2,  4);
      step(VLD,              5'b11111, 4'b0000, 0, 2'b00, 0, 0,  0,  0);
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
